// File: rtl/icache_axi_fill.sv
// rtl/icache_axi_fill.sv - direct-mapped instruction cache refilled by AXI4 INCR read bursts
// Hits are answered combinationally; a miss fetches the whole line as one burst.
module icache_axi_fill #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         LINE_WORDS = 4,
    parameter int         NUM_LINES  = 8,
    parameter logic [0:0] AXI_ID     = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  miss,
    output logic                  fetch_err,
    output logic                  m00_axi_arid,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [7:0]            m00_axi_arlen,
    output logic [2:0]            m00_axi_arsize,
    output logic [1:0]            m00_axi_arburst,
    output logic [3:0]            m00_axi_arcache,
    output logic [2:0]            m00_axi_arprot,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic                  m00_axi_rid,
    input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rlast,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);
    localparam int B = $clog2(DATA_WIDTH / 8);
    localparam int W = $clog2(LINE_WORDS);
    localparam int I = $clog2(NUM_LINES);
    localparam int T = ADDR_WIDTH - B - W - I;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_RD} state_t;

    state_t                state;
    logic [NUM_LINES-1:0]  valid;
    logic [T-1:0]          tags  [NUM_LINES];
    logic [DATA_WIDTH-1:0] words [NUM_LINES*LINE_WORDS];

    logic [W-1:0] offset;
    logic [I-1:0] index;
    logic [T-1:0] tag;
    logic         hit;

    logic [I-1:0] fill_index;
    logic [T-1:0] fill_tag;
    logic [W-1:0] beat;
    logic         err_seen;
    logic         flush_seen;
    logic         beat_take;
    logic         last_take;
    logic         beat_err;
    logic         unused_bits;

    assign offset = addr[B +: W];
    assign index  = addr[B+W +: I];
    assign tag    = addr[ADDR_WIDTH-1 -: T];
    assign hit    = valid[index] && (tags[index] == tag);
    assign miss   = en && !hit;
    assign data   = hit ? words[{index, offset}] : '0;

    assign m00_axi_arid    = AXI_ID[0];
    assign m00_axi_araddr  = {fill_tag, fill_index, {(W+B){1'b0}}};
    assign m00_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m00_axi_arsize  = 3'(B);
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_arcache = 4'b0011;
    assign m00_axi_arprot  = 3'b100;

    assign beat_take   = m00_axi_rready && m00_axi_rvalid;
    assign last_take   = beat_take && m00_axi_rlast;
    assign beat_err    = |m00_axi_rresp;
    assign unused_bits = ^{m00_axi_rid, addr[B-1:0]};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= S_IDLE;
            valid           <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            fetch_err       <= 1'b0;
            fill_index      <= '0;
            fill_tag        <= '0;
            beat            <= '0;
            err_seen        <= 1'b0;
            flush_seen      <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            if (flush) begin
                valid <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (miss && !flush) begin
                        state           <= S_AR;
                        m00_axi_arvalid <= 1'b1;
                        fill_index      <= index;
                        fill_tag        <= tag;
                        beat            <= '0;
                        err_seen        <= 1'b0;
                        flush_seen      <= 1'b0;
                        valid[index]    <= 1'b0;
                    end
                end
                S_AR: begin
                    if (flush) begin
                        flush_seen <= 1'b1;
                    end
                    if (m00_axi_arready) begin
                        state           <= S_RD;
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                    end
                end
                S_RD: begin
                    if (flush) begin
                        flush_seen <= 1'b1;
                    end
                    if (beat_take) begin
                        beat     <= beat + 1'b1;
                        err_seen <= err_seen || beat_err;
                        // An errored, truncated-by-flush or flushed line is left invalid so it is refetched.
                        if (m00_axi_rlast) begin
                            state          <= S_IDLE;
                            m00_axi_rready <= 1'b0;
                            fetch_err      <= err_seen || beat_err;
                            if (!(err_seen || beat_err) && !(flush_seen || flush)) begin
                                valid[fill_index] <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (beat_take) begin
            words[{fill_index, beat}] <= m00_axi_rdata;
        end
        if (last_take) begin
            tags[fill_index] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_axi_fill.sv
// tb/tb_icache_axi_fill.sv - directed and randomized check of icache_axi_fill against a line-level cache model
module tb_icache_axi_fill;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] addr = '0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] data;
    logic        miss, fetch_err;
    logic        arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic        rid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    icache_axi_fill dut (
        .Clk(Clk), .Rst(Rst), .addr(addr), .en(en), .flush(flush),
        .data(data), .miss(miss), .fetch_err(fetch_err),
        .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
        .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arcache(arcache),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rid(rid), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
        .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    always #5 Clk = ~Clk;

    // Cache model: 8 lines of 4 words, index addr[6:4], tag addr[31:7].
    logic [7:0]  m_valid;
    logic [24:0] m_tag [8];
    logic [31:0] m_data [32];
    bit          m_busy, m_ar, m_err, m_flushed, m_fe;
    logic [31:0] m_line;
    logic [1:0]  m_beat;

    bit          s_pending;
    logic [31:0] s_addr;
    int          s_beat, s_gap, s_arcnt, s_len, s_err_beat;
    int          ar_delay = 0, r_gap = 0, cfg_len = 4, cfg_err = -1;
    bit          rand_mode = 0;

    int          vectors = 0, miscompares = 0, cyc = 0, ar_count = 0;
    logic [31:0] last_araddr = '0;
    logic [7:0]  last_arlen = '0;
    logic [2:0]  last_arsize = '0;
    logic [1:0]  last_arburst = '0;

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[31:7]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_valid = '0; m_busy = 0; m_ar = 0; m_err = 0; m_flushed = 0; m_fe = 0; m_beat = '0;
        s_pending = 0; s_arcnt = 0; s_gap = 0; s_beat = 0;
    endtask

    task automatic drive_slave();
        if (!s_pending) begin
            arready = arvalid && (rand_mode ? ($urandom_range(0, 2) == 0) : (s_arcnt == ar_delay));
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        end else begin
            arready = 1'b0;
            rvalid = rand_mode ? ($urandom_range(0, 2) != 0) : (s_gap == 0);
            rdata = slave_word(s_addr + 32'(s_beat * 4));
            rresp = (s_beat == s_err_beat) ? 2'b10 : 2'b00;
            rlast = (s_beat == s_len - 1);
        end
    endtask

    task automatic compare();
        bit h = m_hit(addr);
        check("miss", 32'(miss), 32'(en && !h));
        check("data", data, h ? m_data[{addr[6:4], addr[3:2]}] : 32'h0);
        check("arvalid", 32'(arvalid), 32'(m_busy && !m_ar));
        check("rready", 32'(rready), 32'(m_busy && m_ar));
        check("fetch_err", 32'(fetch_err), 32'(m_fe));
        if (m_busy && !m_ar) begin
            check("araddr", araddr, m_line);
            check("arlen", 32'(arlen), 32'd3);
            check("arsize", 32'(arsize), 32'd2);
            check("arburst", 32'(arburst), 32'd1);
            check("arcache", 32'(arcache), 32'd3);
            check("arprot", 32'(arprot), 32'd4);
            check("arid", 32'(arid), 32'd0);
        end
    endtask

    // Applies the effect of the coming clock edge to slave and model.
    task automatic advance();
        bit          nfe = 0;
        logic [2:0]  ix;
        if (!Rst) begin
            if (!s_pending) begin
                if (arvalid && arready) begin
                    s_pending = 1; s_addr = araddr; s_beat = 0; s_gap = 0; s_arcnt = 0;
                    ar_count++; last_araddr = araddr; last_arlen = arlen;
                    last_arsize = arsize; last_arburst = arburst;
                    if (rand_mode) begin
                        s_len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 4;
                        s_err_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
                    end else begin
                        s_len = cfg_len; s_err_beat = cfg_err;
                    end
                end else if (arvalid) begin
                    s_arcnt++;
                end
            end else if (rvalid && rready) begin
                if (rlast) s_pending = 0;
                else begin s_beat++; s_gap = r_gap; end
            end else if (s_gap > 0) begin
                s_gap--;
            end

            if (flush) begin
                m_valid = '0;
                if (m_busy) m_flushed = 1;
            end
            if (!m_busy) begin
                if (en && !m_hit(addr) && !flush) begin
                    m_busy = 1; m_ar = 0; m_line = addr & 32'hFFFF_FFF0;
                    m_beat = '0; m_err = 0; m_flushed = 0; m_valid[addr[6:4]] = 1'b0;
                end
            end else if (!m_ar) begin
                if (arready) m_ar = 1;
            end else if (rvalid) begin
                ix = m_line[6:4];
                m_data[{ix, m_beat}] = rdata;
                m_beat = m_beat + 2'd1;
                m_err = m_err || (rresp != 2'b00);
                if (rlast) begin
                    m_busy = 0;
                    m_tag[ix] = m_line[31:7];
                    if (!m_err && !m_flushed) m_valid[ix] = 1'b1;
                    nfe = m_err;
                end
            end
            m_fe = nfe;
        end
    endtask

    task automatic step(input logic [31:0] a, input bit e, input bit f, input bit r);
        @(negedge Clk);
        addr = a; en = e; flush = f; Rst = r;
        if (r) model_reset();
        drive_slave();
        #1;
        compare();
        advance();
        cyc++;
    endtask

    task automatic wait_hit(input logic [31:0] a, input int maxc, output int c);
        c = 0;
        step(a, 1, 0, 0);
        while (miss && c < maxc) begin
            step(a, 1, 0, 0);
            c++;
        end
    endtask

    int          c, n0;
    logic [31:0] ra;

    initial begin
        model_reset();
        step(32'h100, 1, 0, 1);
        check("reset_miss_follows_en", 32'(miss), 32'd1);
        check("reset_data", data, 32'h0);
        step(32'h0, 0, 0, 0);
        check("idle_miss_en0", 32'(miss), 32'd0);

        // Cold fetch with zero-wait slave
        n0 = ar_count;
        wait_hit(32'h100, 60, c);
        check("cold_miss_cycles", 32'(c), 32'd6);
        check("cold_araddr", last_araddr, 32'h100);
        check("cold_arlen", 32'(last_arlen), 32'd3);
        check("cold_arsize", 32'(last_arsize), 32'd2);
        check("cold_arburst", 32'(last_arburst), 32'd1);
        check("cold_data0", data, 32'hA0);
        step(32'h104, 1, 0, 0); check("hit_104", data, 32'hA1);
        step(32'h108, 1, 0, 0); check("hit_108", data, 32'hA2);
        step(32'h10C, 1, 0, 0); check("hit_10c", data, 32'hA3);
        check("hit_10c_miss", 32'(miss), 32'd0);
        check("cold_ar_count", 32'(ar_count - n0), 32'd1);

        // Conflict on index 0
        n0 = ar_count;
        wait_hit(32'h180, 60, c);
        check("conflict_cycles", 32'(c), 32'd6);
        check("conflict_araddr", last_araddr, 32'h180);
        check("conflict_data", data, 32'hC0);
        check("conflict_ar_count", 32'(ar_count - n0), 32'd1);
        step(32'h100, 1, 0, 0);
        check("conflict_evicted", 32'(miss), 32'd1);
        wait_hit(32'h100, 60, c);
        check("refill_cycles", 32'(c), 32'd5);

        // ARREADY stalls and gapped beats
        ar_delay = 3; r_gap = 2;
        wait_hit(32'h200, 60, c);
        check("stall_miss_cycles", 32'(c), 32'd15);
        check("stall_data", data, 32'hE0);
        ar_delay = 0; r_gap = 0;

        // SLVERR on beat 2, then a clean retry
        cfg_err = 2;
        for (int i = 0; i < 6; i++) step(32'h240, 1, 0, 0);
        cfg_err = -1;
        step(32'h240, 1, 0, 0);
        check("err_pulse", 32'(fetch_err), 32'd1);
        check("err_line_invalid", 32'(miss), 32'd1);
        step(32'h240, 1, 0, 0);
        check("err_pulse_end", 32'(fetch_err), 32'd0);
        check("err_retry_ar", 32'(arvalid), 32'd1);
        wait_hit(32'h240, 60, c);
        check("retry_cycles", 32'(c), 32'd4);
        check("retry_data", data, 32'hF0);

        // Flush during beat 1
        for (int i = 0; i < 3; i++) step(32'h2C0, 1, 0, 0);
        step(32'h2C0, 1, 1, 0);
        step(32'h2C0, 1, 0, 0);
        step(32'h2C0, 1, 0, 0);
        step(32'h2C0, 1, 0, 0);
        check("flush_not_validated", 32'(miss), 32'd1);
        step(32'h2C0, 1, 0, 0);
        check("flush_refetch_ar", 32'(arvalid), 32'd1);
        check("flush_refetch_addr", araddr, 32'h2C0);
        wait_hit(32'h2C0, 60, c);
        check("flush_refill_cycles", 32'(c), 32'd4);
        step(32'h2C0, 0, 1, 0);
        step(32'h104, 1, 0, 0); check("post_flush_104", 32'(miss), 32'd1);
        step(32'h2C0, 1, 0, 0); check("post_flush_2c0", 32'(miss), 32'd1);
        step(32'h180, 1, 0, 0); check("post_flush_180", 32'(miss), 32'd1);
        wait_hit(32'h104, 60, c);
        check("post_flush_fill_done", 32'(c < 60), 32'd1);

        // Reset during beat 2
        step(32'h100, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(32'h100, 1, 0, 0);
        step(32'h100, 1, 0, 1);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        step(32'h100, 1, 0, 1);
        n0 = ar_count;
        wait_hit(32'h100, 60, c);
        check("rst_refetch_cycles", 32'(c), 32'd6);
        check("rst_refetch_ar", 32'(ar_count - n0), 32'd1);
        check("rst_refetch_data", data, 32'hA0);

        // Randomized traffic
        rand_mode = 1;
        n0 = ar_count;
        ra = 32'h0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0)
                ra = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
            step(ra, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 399) == 0);
        end
        check("random_activity", 32'(ar_count - n0 > 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
